// File: rtl/aes_affine_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aes_affine_pipe: elastic multi-lane AES forward/inverse affine stage.      |
// | Optional AES_AFFINE_BYPASS_EN adds raw pass-through beats. Rev 1.0         |
// +----------------------------------------------------------------------------+
module aes_affine_pipe #(
    parameter int LANES       = 4,
    parameter int PIPE_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_mode,
    input  logic [8*LANES-1:0]   in_data,
`ifdef AES_AFFINE_BYPASS_EN
    input  logic                 in_bypass,
    output logic                 out_bypass,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_mode,
    output logic [8*LANES-1:0]   out_data
);

    localparam logic [7:0] c_fwd_const = 8'h63;
    localparam logic [7:0] c_inv_const = 8'h05;

    // Bit equations rewritten as XORs of left rotations: a_(i+k) == rotl(a, 8-k).
    function automatic logic [7:0] fwd_affine(input logic [7:0] a);
        return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]}
                 ^ {a[3:0], a[7:4]} ^ c_fwd_const;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] a);
        return {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ c_inv_const;
    endfunction

    logic [8*LANES-1:0]     w_xform;
    logic [8*LANES-1:0]     w_stage_in;
    logic [PIPE_STAGES-1:0] w_load;

    logic [PIPE_STAGES-1:0] r_valid;
    logic [PIPE_STAGES-1:0] r_mode;
    logic [8*LANES-1:0]     r_data [PIPE_STAGES];

    genvar k;
    generate
        for (k = 0; k < LANES; k++) begin : g_lane
            assign w_xform[8*k +: 8] = in_mode ? inv_affine(in_data[8*k +: 8])
                                               : fwd_affine(in_data[8*k +: 8]);
        end
    endgenerate

`ifdef AES_AFFINE_BYPASS_EN
    assign w_stage_in = in_bypass ? in_data : w_xform;
`else
    assign w_stage_in = w_xform;
`endif

    // A stage may load when any stage from it to the output is empty, or the
    // output drains; this flattens the combinational ready chain.
    genvar s;
    generate
        for (s = 0; s < PIPE_STAGES; s++) begin : g_load
            assign w_load[s] = out_ready | ~(&r_valid[PIPE_STAGES-1:s]);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_mode  <= '0;
            for (int i = 0; i < PIPE_STAGES; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            if (w_load[0]) begin
                r_valid[0] <= in_valid;
                if (in_valid) begin
                    r_data[0] <= w_stage_in;
                    r_mode[0] <= in_mode;
                end
            end
            for (int i = 1; i < PIPE_STAGES; i++) begin
                if (w_load[i]) begin
                    r_valid[i] <= r_valid[i-1];
                    if (r_valid[i-1]) begin
                        r_data[i] <= r_data[i-1];
                        r_mode[i] <= r_mode[i-1];
                    end
                end
            end
        end
    end

`ifdef AES_AFFINE_BYPASS_EN
    logic [PIPE_STAGES-1:0] r_byp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byp <= '0;
        end else begin
            if (w_load[0] && in_valid) begin
                r_byp[0] <= in_bypass;
            end
            for (int i = 1; i < PIPE_STAGES; i++) begin
                if (w_load[i] && r_valid[i-1]) begin
                    r_byp[i] <= r_byp[i-1];
                end
            end
        end
    end

    assign out_bypass = r_byp[PIPE_STAGES-1];
`endif

    assign in_ready  = w_load[0];
    assign out_valid = r_valid[PIPE_STAGES-1];
    assign out_mode  = r_mode[PIPE_STAGES-1];
    assign out_data  = r_data[PIPE_STAGES-1];

endmodule
`default_nettype wire
